// File: rtl/heap_pq_unit.sv
// Binary heap priority queue serving push_heap/pop_heap commands, one command per handshake.
// Latency: PEEK/CLEAR/error 1 cycle; PUSH 2..log2(DEPTH)+2; POP 2..log2(DEPTH)+1.
// Backpressure: cmd_ready only in IDLE; the response is held in RESP until rsp_ready.
//
// Ports: clk/reset_n (async active-low); cmd_valid/cmd_ready/cmd_op/cmd_data command channel;
//        rsp_valid/rsp_ready/rsp_data/rsp_err response channel; count/full/empty occupancy status.
// Build option: define HEAP_MAX_EN for a max-heap (largest key at the root); default is a min-heap.
module heap_pq_unit #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 1024
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic [1:0]                cmd_op,
   input  logic [DATA_W-1:0]         cmd_data,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [DATA_W-1:0]         rsp_data,
   output logic                      rsp_err,
   output logic [$clog2(DEPTH):0]    count,
   output logic                      full,
   output logic                      empty
);

   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam int IDX_W = $clog2(DEPTH);

   localparam logic [1:0] OP_PUSH  = 2'b00;
   localparam logic [1:0] OP_POP   = 2'b01;
   localparam logic [1:0] OP_PEEK  = 2'b10;
   localparam logic [1:0] OP_CLEAR = 2'b11;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      SIFT_UP   = 2'd1,
      SIFT_DOWN = 2'd2,
      RESP      = 2'd3
   } state_t;

   state_t state, state_nxt;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [IDX_W-1:0]  idx;

   // True when 'upper' may legally sit above 'lower' in the heap.
   function automatic logic keep_order(input logic [DATA_W-1:0] upper,
                                       input logic [DATA_W-1:0] lower);
`ifdef HEAP_MAX_EN
      return upper >= lower;
`else
      return upper <= lower;
`endif
   endfunction

   // Tree neighbourhood of the current index.
   logic [IDX_W-1:0]  par_a, lc_a, rc_a, c_a, push_a, last_a;
   logic [CNT_W-1:0]  lc;
   logic              l_vld, r_vld, pick_r;
   logic [DATA_W-1:0] cur_k, par_k, l_k, r_k, c_k;
   logic              up_done, dn_done;
   logic              accept, push_ok, pop_ok;

   always_comb begin
      par_a  = (idx - IDX_W'(1)) >> 1;
      lc     = {idx, 1'b1};
      lc_a   = lc[IDX_W-1:0];
      rc_a   = lc_a + IDX_W'(1);
      // Only low bits matter: when count==DEPTH they wrap to zero, and the
      // decrement lands exactly on DEPTH-1.
      push_a = count[IDX_W-1:0];
      last_a = count[IDX_W-1:0] - IDX_W'(1);
      l_vld  = lc < count;
      // lc is odd, so lc+1 < count is the same as lc < count and lc+1 != count.
      r_vld  = l_vld && ((lc + CNT_W'(1)) != count);
      cur_k  = mem[idx];
      par_k  = mem[par_a];
      l_k    = mem[lc_a];
      r_k    = mem[rc_a];
      // Right child only when strictly better; ties stay left.
      pick_r = r_vld && !keep_order(l_k, r_k);
      c_a    = pick_r ? rc_a : lc_a;
      c_k    = pick_r ? r_k  : l_k;
      up_done = (idx == '0) || keep_order(par_k, cur_k);
      dn_done = !l_vld || keep_order(cur_k, c_k);
      accept  = cmd_valid && (state == IDLE);
      push_ok = accept && (cmd_op == OP_PUSH) && !full;
      pop_ok  = accept && (cmd_op == OP_POP)  && !empty;
   end

   assign full  = (count == CNT_W'(DEPTH));
   assign empty = (count == '0);

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   // Next state and handshake outputs
   always_comb begin
      state_nxt = state;
      cmd_ready = 1'b0;
      rsp_valid = 1'b0;
      case (state)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               if (push_ok)     state_nxt = SIFT_UP;
               else if (pop_ok) state_nxt = SIFT_DOWN;
               else             state_nxt = RESP;
            end
         end
         SIFT_UP:   if (up_done) state_nxt = RESP;
         SIFT_DOWN: if (dn_done) state_nxt = RESP;
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Occupancy, walk index and response registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count    <= '0;
         idx      <= '0;
         rsp_data <= '0;
         rsp_err  <= 1'b0;
      end else begin
         case (state)
            IDLE: if (accept) begin
               rsp_err  <= 1'b0;
               rsp_data <= '0;
               case (cmd_op)
                  OP_PUSH: begin
                     if (full) rsp_err <= 1'b1;
                     else begin
                        count    <= count + CNT_W'(1);
                        idx      <= push_a;
                        rsp_data <= DATA_W'(count) + DATA_W'(1);
                     end
                  end
                  OP_POP: begin
                     if (empty) rsp_err <= 1'b1;
                     else begin
                        count    <= count - CNT_W'(1);
                        idx      <= '0;
                        rsp_data <= mem[0];
                     end
                  end
                  OP_PEEK: begin
                     if (empty) rsp_err <= 1'b1;
                     else       rsp_data <= mem[0];
                  end
                  OP_CLEAR: count <= '0;
                  default: ;
               endcase
            end
            SIFT_UP:   if (!up_done) idx <= par_a;
            SIFT_DOWN: if (!dn_done) idx <= c_a;
            default: ;
         endcase
      end
   end

   // Key storage: not reset; one or two writes per cycle (swap).
   always_ff @(posedge clk) begin
      if (push_ok) mem[push_a] <= cmd_data;
      // Last element moves to the root; with count==1 this rewrites mem[0] with itself.
      if (pop_ok)  mem[0] <= mem[last_a];
      if (state == SIFT_UP && !up_done) begin
         mem[par_a] <= cur_k;
         mem[idx]   <= par_k;
      end
      if (state == SIFT_DOWN && !dn_done) begin
         mem[c_a] <= cur_k;
         mem[idx] <= c_k;
      end
   end

endmodule

// File: tb/tb_heap_pq_unit.sv
// Directed bench for heap_pq_unit with DEPTH=4.
// Expected values are hand-computed; HEAP_MAX_EN selects the max-heap expectations.
// Inputs are driven and outputs sampled 1 time unit after the rising edge.
module tb_heap_pq_unit;

   localparam int DATA_W = 32;
   localparam int DEPTH  = 4;
   localparam int CNT_W  = 3;

   localparam logic [1:0] OP_PUSH  = 2'b00;
   localparam logic [1:0] OP_POP   = 2'b01;
   localparam logic [1:0] OP_PEEK  = 2'b10;
   localparam logic [1:0] OP_CLEAR = 2'b11;

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic              cmd_valid = 1'b0;
   logic              cmd_ready;
   logic [1:0]        cmd_op = 2'b00;
   logic [DATA_W-1:0] cmd_data = '0;
   logic              rsp_valid;
   logic              rsp_ready = 1'b0;
   logic [DATA_W-1:0] rsp_data;
   logic              rsp_err;
   logic [CNT_W-1:0]  count;
   logic              full;
   logic              empty;

   int vecs = 0;
   int errs = 0;

   always #5 clk = ~clk;

   heap_pq_unit #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset_n(reset_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
      .count(count), .full(full), .empty(empty)
   );

   // Present one command, wait (bounded) for the response; lat counts cycles from the accept edge.
   task automatic send_cmd(input logic [1:0] op, input logic [DATA_W-1:0] d, output int lat);
      cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
      @(posedge clk); #1;
      cmd_valid = 1'b0; cmd_data = '0;
      lat = 1;
      while (!rsp_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic ack();
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      int lat;
      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      vecs++;
      if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || count !== 3'd0 || empty !== 1'b1 ||
          full !== 1'b0 || rsp_data !== 32'd0 || rsp_err !== 1'b0) begin
         $display("FAIL reset_state: valid=%b ready=%b count=%0d empty=%b full=%b data=%0d err=%b, want 0 1 0 1 0 0 0",
                  rsp_valid, cmd_ready, count, empty, full, rsp_data, rsp_err);
         errs++;
      end
      reset_n = 1'b1;
      @(posedge clk); #1;
      send_cmd(OP_PEEK, 32'd0, lat);
      vecs++;
      if (rsp_err !== 1'b1 || rsp_data !== 32'd0 || lat !== 1 || count !== 3'd0 || empty !== 1'b1) begin
         $display("FAIL peek_empty: err=%b data=%0d lat=%0d count=%0d empty=%b, want 1 0 1 0 1",
                  rsp_err, rsp_data, lat, count, empty);
         errs++;
      end
      ack();
   endtask

   task automatic test_push_pop();
      int lat;
      logic [DATA_W-1:0] keys [4];
      logic [DATA_W-1:0] exp_pop [4];
      keys = '{32'd5, 32'd3, 32'd8, 32'd1};
`ifdef HEAP_MAX_EN
      exp_pop = '{32'd8, 32'd5, 32'd3, 32'd1};
`else
      exp_pop = '{32'd1, 32'd3, 32'd5, 32'd8};
`endif
      for (int i = 0; i < 4; i++) begin
         send_cmd(OP_PUSH, keys[i], lat);
         vecs++;
         if (rsp_err !== 1'b0 || rsp_data !== 32'(i + 1)) begin
            $display("FAIL push_count[%0d]: err=%b data=%0d, want 0 %0d", i, rsp_err, rsp_data, i + 1);
            errs++;
         end
         ack();
      end
      vecs++;
      if (full !== 1'b1 || count !== 3'd4) begin
         $display("FAIL full_after_4: full=%b count=%0d, want 1 4", full, count);
         errs++;
      end
      for (int i = 0; i < 4; i++) begin
         send_cmd(OP_POP, 32'd0, lat);
         vecs++;
         if (rsp_err !== 1'b0 || rsp_data !== exp_pop[i]) begin
            $display("FAIL pop_order[%0d]: err=%b data=%0d, want 0 %0d", i, rsp_err, rsp_data, exp_pop[i]);
            errs++;
         end
         ack();
      end
      vecs++;
      if (empty !== 1'b1 || count !== 3'd0) begin
         $display("FAIL empty_after_pops: empty=%b count=%0d, want 1 0", empty, count);
         errs++;
      end
   endtask

   task automatic test_full();
      int lat;
      logic [DATA_W-1:0] keys [4];
      logic [DATA_W-1:0] exp_pop [2];
      keys = '{32'd9, 32'd7, 32'd7, 32'd2};
`ifdef HEAP_MAX_EN
      exp_pop = '{32'd9, 32'd7};
`else
      exp_pop = '{32'd2, 32'd7};
`endif
      for (int i = 0; i < 4; i++) begin
         send_cmd(OP_PUSH, keys[i], lat);
         ack();
      end
      send_cmd(OP_PUSH, 32'd6, lat);
      vecs++;
      if (rsp_err !== 1'b1 || rsp_data !== 32'd0 || lat !== 1 || full !== 1'b1 || count !== 3'd4) begin
         $display("FAIL push_full: err=%b data=%0d lat=%0d full=%b count=%0d, want 1 0 1 1 4",
                  rsp_err, rsp_data, lat, full, count);
         errs++;
      end
      ack();
      for (int i = 0; i < 2; i++) begin
         send_cmd(OP_POP, 32'd0, lat);
         vecs++;
         if (rsp_err !== 1'b0 || rsp_data !== exp_pop[i]) begin
            $display("FAIL pop_after_full[%0d]: err=%b data=%0d, want 0 %0d", i, rsp_err, rsp_data, exp_pop[i]);
            errs++;
         end
         ack();
      end
      send_cmd(OP_CLEAR, 32'd0, lat);
      vecs++;
      if (rsp_err !== 1'b0 || rsp_data !== 32'd0 || lat !== 1 || count !== 3'd0 || empty !== 1'b1) begin
         $display("FAIL clear: err=%b data=%0d lat=%0d count=%0d empty=%b, want 0 0 1 0 1",
                  rsp_err, rsp_data, lat, count, empty);
         errs++;
      end
      ack();
   endtask

   task automatic test_descending();
      int lat;
      int exp_lat [4];
      logic [DATA_W-1:0] exp_peek;
`ifdef HEAP_MAX_EN
      exp_lat = '{2, 2, 2, 2};
`else
      exp_lat = '{2, 3, 3, 4};
`endif
      for (int i = 0; i < 4; i++) begin
         send_cmd(OP_PUSH, 32'(3 - i), lat);
         vecs++;
         if (lat !== exp_lat[i] || rsp_err !== 1'b0) begin
            $display("FAIL push_latency[%0d]: lat=%0d err=%b, want %0d 0", i, lat, rsp_err, exp_lat[i]);
            errs++;
         end
         ack();
`ifdef HEAP_MAX_EN
         exp_peek = 32'd3;
`else
         exp_peek = 32'(3 - i);
`endif
         send_cmd(OP_PEEK, 32'd0, lat);
         vecs++;
         if (rsp_data !== exp_peek || rsp_err !== 1'b0 || lat !== 1) begin
            $display("FAIL peek_root[%0d]: data=%0d err=%b lat=%0d, want %0d 0 1",
                     i, rsp_data, rsp_err, lat, exp_peek);
            errs++;
         end
         ack();
      end
      send_cmd(OP_CLEAR, 32'd0, lat);
      ack();
   endtask

   task automatic test_stall();
      int lat;
      logic [DATA_W-1:0] exp_k;
`ifdef HEAP_MAX_EN
      exp_k = 32'd5;
`else
      exp_k = 32'd3;
`endif
      send_cmd(OP_PUSH, 32'd5, lat); ack();
      send_cmd(OP_PUSH, 32'd3, lat); ack();
      send_cmd(OP_POP, 32'd0, lat);
      for (int c = 0; c < 10; c++) begin
         vecs++;
         if (rsp_valid !== 1'b1 || rsp_data !== exp_k || rsp_err !== 1'b0 || cmd_ready !== 1'b0) begin
            $display("FAIL stall_hold[%0d]: valid=%b data=%0d err=%b ready=%b, want 1 %0d 0 0",
                     c, rsp_valid, rsp_data, rsp_err, cmd_ready, exp_k);
            errs++;
         end
         @(posedge clk); #1;
      end
      ack();
      vecs++;
      if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || count !== 3'd1) begin
         $display("FAIL stall_release: valid=%b ready=%b count=%0d, want 0 1 1", rsp_valid, cmd_ready, count);
         errs++;
      end
      send_cmd(OP_CLEAR, 32'd0, lat); ack();
   endtask

   task automatic test_reset_mid_sift();
      int lat;
      logic [DATA_W-1:0] keys [4];
      keys = '{32'd5, 32'd3, 32'd8, 32'd1};
      for (int i = 0; i < 4; i++) begin
         send_cmd(OP_PUSH, keys[i], lat);
         ack();
      end
      // Root replaced by the last key, which must sink one level: SIFT_DOWN lasts more than one cycle.
      cmd_valid = 1'b1; cmd_op = OP_POP;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      reset_n = 1'b0;
      #1;
      vecs++;
      if (rsp_valid !== 1'b0 || count !== 3'd0 || cmd_ready !== 1'b1 || empty !== 1'b1) begin
         $display("FAIL reset_mid_sift: valid=%b count=%0d ready=%b empty=%b, want 0 0 1 1",
                  rsp_valid, count, cmd_ready, empty);
         errs++;
      end
      @(posedge clk); #2;
      reset_n = 1'b1;
      @(posedge clk); #1;
      send_cmd(OP_PUSH, 32'd4, lat);
      vecs++;
      if (rsp_data !== 32'd1 || rsp_err !== 1'b0) begin
         $display("FAIL push_after_reset: data=%0d err=%b, want 1 0", rsp_data, rsp_err);
         errs++;
      end
      ack();
      send_cmd(OP_POP, 32'd0, lat);
      vecs++;
      if (rsp_data !== 32'd4 || rsp_err !== 1'b0 || lat !== 2 || empty !== 1'b1) begin
         $display("FAIL pop_after_reset: data=%0d err=%b lat=%0d empty=%b, want 4 0 2 1",
                  rsp_data, rsp_err, lat, empty);
         errs++;
      end
      ack();
   endtask

   initial begin
      test_reset();
      test_push_pop();
      test_full();
      test_descending();
      test_stall();
      test_reset_mid_sift();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
